// File: rtl/bitcnt_pkg.sv
// Shared definitions for the bit-count arbiter: operand/function widths,
// function codes and the response buffer state encoding.
package bitcnt_pkg;

   localparam int FUNC_W = 3;
   localparam int DATA_W = 64;

   typedef enum logic [FUNC_W-1:0] {
      FUNC_POPCNT64 = 3'b000,
      FUNC_POPCNT32 = 3'b001,
      FUNC_CLZ64    = 3'b010,
      FUNC_CLZ32    = 3'b011,
      FUNC_CTZ64    = 3'b100,
      FUNC_CTZ32    = 3'b101
   } func_t;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

   // Codes 110 and 111 have no operation behind them.
   function automatic logic is_legal_func(input logic [FUNC_W-1:0] func);
      return (func != 3'b110) && (func != 3'b111);
   endfunction

endpackage

// File: rtl/bitcnt_rr_pick.sv
// Rotating-priority picker: the search starts one past ptr and wraps, so
// the index in ptr itself has the lowest priority this cycle.
module bitcnt_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 1; k <= N; k++) begin
         if (!grant_any && req[(int'(ptr) + k) % N]) begin
            grant_any                     = 1'b1;
            grant[(int'(ptr) + k) % N]    = 1'b1;
            grant_idx                     = IW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/bitcnt_arbiter.sv
// Round-robin sharing of one combinational bit-count unit between NREQ
// requesters, with a single-entry response register on the output side.
module bitcnt_arbiter
   import bitcnt_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2,
   parameter int CNTW = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic [NREQ*FUNC_W-1:0]   req_func,
   output logic [DATA_W-1:0]        bc_din_data,
   output logic [FUNC_W-1:0]        bc_din_func,
   input  logic [DATA_W-1:0]        bc_dout_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_err,
   output logic [CNTW-1:0]          op_count
);

   rsp_state_t          state_q, state_d;
   logic                can_accept;
   logic                handshake;
   logic                func_legal;
   logic [NREQ-1:0]     grant;
   logic [IDW-1:0]      grant_idx;
   logic                grant_any;
   logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]      rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                rsp_err_q, rsp_err_d;
   logic [CNTW-1:0]     op_count_q, op_count_d;

   bitcnt_rr_pick #(
      .N  (NREQ),
      .IW (IDW)
   ) u_pick (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // The unit sees the granted operand even when the buffer stalls; it is
   // purely combinational so this costs nothing and keeps the mux simple.
   always_comb begin
      bc_din_data = '0;
      bc_din_func = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            bc_din_data = req_data[i*DATA_W +: DATA_W];
            bc_din_func = req_func[i*FUNC_W +: FUNC_W];
         end
      end
   end

   assign func_legal = is_legal_func(bc_din_func);
   assign handshake  = grant_any && can_accept && !reset;
   assign req_ready  = (can_accept && !reset) ? grant : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RSP_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RSP_EMPTY: if (handshake)               state_d = RSP_FULL;
         RSP_FULL:  if (rsp_ready && !handshake) state_d = RSP_EMPTY;
         default:                                state_d = RSP_EMPTY;
      endcase
   end

   // A full buffer can take a new result only in the cycle it drains.
   always_comb begin
      can_accept = 1'b0;
      rsp_valid  = 1'b0;
      case (state_q)
         RSP_EMPTY: can_accept = 1'b1;
         RSP_FULL: begin
            can_accept = rsp_ready;
            rsp_valid  = 1'b1;
         end
         default: can_accept = 1'b0;
      endcase
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      op_count_d = op_count_q;
      if (handshake) begin
         rr_ptr_d   = grant_idx;
         rsp_id_d   = grant_idx;
         rsp_err_d  = !func_legal;
         rsp_data_d = func_legal ? bc_dout_data : '0;
         if (op_count_q != '1) begin
            op_count_d = op_count_q + CNTW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q   <= IDW'(NREQ - 1);
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         op_count_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         op_count_q <= op_count_d;
      end
   end

   assign rsp_id   = rsp_id_q;
   assign rsp_data = rsp_data_q;
   assign rsp_err  = rsp_err_q;
   assign op_count = op_count_q;

endmodule

// File: tb/tb_bitcnt_arbiter.sv
// Bench for bitcnt_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_bitcnt_arbiter;
   import bitcnt_pkg::*;

   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int CNTW  = 32;
   localparam int SCNTW = 3;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ*64-1:0]  req_data = '0;
   logic [NREQ*3-1:0]   req_func = '0;
   logic                rsp_ready = 1'b0;

   logic [NREQ-1:0]     req_ready, req_ready_s;
   logic [63:0]         bc_din_data, bc_din_data_s, bc_dout_data, bc_dout_data_s;
   logic [2:0]          bc_din_func, bc_din_func_s;
   logic                rsp_valid, rsp_valid_s, rsp_err, rsp_err_s;
   logic [IDW-1:0]      rsp_id, rsp_id_s;
   logic [63:0]         rsp_data, rsp_data_s;
   logic [CNTW-1:0]     op_count;
   logic [SCNTW-1:0]    op_count_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bitcnt_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_func(req_func), .bc_din_data(bc_din_data),
      .bc_din_func(bc_din_func), .bc_dout_data(bc_dout_data), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .op_count(op_count));

   // Narrow counter copy so saturation is reachable within the run.
   bitcnt_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(SCNTW)) dut_sat (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_s),
      .req_data(req_data), .req_func(req_func), .bc_din_data(bc_din_data_s),
      .bc_din_func(bc_din_func_s), .bc_dout_data(bc_dout_data_s), .rsp_valid(rsp_valid_s),
      .rsp_ready(rsp_ready), .rsp_id(rsp_id_s), .rsp_data(rsp_data_s), .rsp_err(rsp_err_s),
      .op_count(op_count_s));

   function automatic logic [63:0] ref_unit(input logic [63:0] d, input logic [2:0] f);
      int n;
      n = 0;
      case (f)
         3'b000: for (int i = 0; i < 64; i++) n += int'(d[i]);
         3'b001: for (int i = 0; i < 32; i++) n += int'(d[i]);
         3'b010: begin n = 64; for (int i = 0; i < 64; i++) if (d[i]) n = 63 - i; end
         3'b011: begin n = 32; for (int i = 0; i < 32; i++) if (d[i]) n = 31 - i; end
         3'b100: begin n = 64; for (int i = 63; i >= 0; i--) if (d[i]) n = i; end
         3'b101: begin n = 32; for (int i = 31; i >= 0; i--) if (d[i]) n = i; end
         default: return 64'hDEAD_BEEF_0BAD_F00D;
      endcase
      return 64'(n);
   endfunction

   always_comb bc_dout_data   = ref_unit(bc_din_data, bc_din_func);
   always_comb bc_dout_data_s = ref_unit(bc_din_data_s, bc_din_func_s);

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Behavioural model: buffered response, last granted index, op total.
   bit          m_full = 1'b0;
   int          m_id = 0;
   logic [63:0] m_data = '0;
   bit          m_err = 1'b0;
   int          m_last = NREQ - 1;
   longint      m_cnt = 0;
   bit          p_hs = 1'b0;
   bit          p_drain = 1'b0;
   int          p_idx = 0;
   logic [63:0] p_data = '0;
   bit          p_err = 1'b0;

   int              g;
   bit              ca;
   logic [NREQ-1:0] er;
   logic [63:0]     ed;
   logic [2:0]      ef;
   longint          sat;

   always @(negedge clk) begin
      if (reset) begin
         checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
         checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         checkOutput("rst_rsp_id", 64'(rsp_id), 64'd0);
         checkOutput("rst_rsp_data", rsp_data, 64'd0);
         checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
         checkOutput("rst_op_count", 64'(op_count), 64'd0);
         p_hs    = 1'b0;
         p_drain = 1'b0;
      end else begin
         g = -1;
         for (int k = 1; k <= NREQ; k++) begin
            if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
         end
         ca = !m_full || rsp_ready;
         er = (g >= 0 && ca) ? NREQ'(1 << g) : '0;
         ed = (g >= 0) ? req_data[g*64 +: 64] : 64'd0;
         ef = (g >= 0) ? req_func[g*3 +: 3] : 3'd0;
         sat = (m_cnt > 7) ? 7 : m_cnt;
         checkOutput("m_req_ready", 64'(req_ready), 64'(er));
         checkOutput("m_req_ready_s", 64'(req_ready_s), 64'(er));
         checkOutput("m_din_data", bc_din_data, ed);
         checkOutput("m_din_func", 64'(bc_din_func), 64'(ef));
         checkOutput("m_rsp_valid", 64'(rsp_valid), 64'(m_full));
         checkOutput("m_rsp_valid_s", 64'(rsp_valid_s), 64'(m_full));
         checkOutput("m_op_count", 64'(op_count), 64'(m_cnt));
         checkOutput("m_op_count_sat", 64'(op_count_s), 64'(sat));
         if (m_full) begin
            checkOutput("m_rsp_id", 64'(rsp_id), 64'(m_id));
            checkOutput("m_rsp_data", rsp_data, m_data);
            checkOutput("m_rsp_err", 64'(rsp_err), 64'(m_err));
            checkOutput("m_rsp_data_s", rsp_data_s, m_data);
            checkOutput("m_rsp_id_s", 64'(rsp_id_s), 64'(m_id));
            checkOutput("m_rsp_err_s", 64'(rsp_err_s), 64'(m_err));
         end
         p_hs    = (g >= 0) && ca;
         p_drain = m_full && rsp_ready;
         p_idx   = g;
         p_err   = (ef == 3'b110) || (ef == 3'b111);
         p_data  = p_err ? 64'd0 : ref_unit(ed, ef);
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_full = 1'b0;
         m_last = NREQ - 1;
         m_cnt  = 0;
      end else begin
         if (p_hs) begin
            m_full = 1'b1;
            m_id   = p_idx;
            m_data = p_data;
            m_err  = p_err;
            m_last = p_idx;
            m_cnt++;
         end else if (p_drain) begin
            m_full = 1'b0;
         end
         p_hs    = 1'b0;
         p_drain = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setOp(input int i, input logic [63:0] d, input logic [2:0] f);
      req_data[i*64 +: 64] = d;
      req_func[i*3 +: 3]   = f;
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic rr);
      req_valid = v;
      rsp_ready = rr;
   endtask

   task automatic resetPulse();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 4))
         0:       return 64'd0;
         1:       return 64'd1 << $urandom_range(0, 63);
         2:       return {$urandom, $urandom};
         3:       return {32'd0, $urandom};
         default: return ~(64'd1 << $urandom_range(0, 63));
      endcase
   endfunction

   logic [63:0]     t5_exp [4] = '{64'd32, 64'd32, 64'd32, 64'd31};
   logic [2:0]      t5_func[4] = '{3'b101, 3'b100, 3'b011, 3'b010};
   logic [NREQ-1:0] acc;

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Single popcount from requester 0.
      setOp(0, 64'hFF, 3'b000);
      applyStimulus(4'b0001, 1'b1);
      @(negedge clk);
      checkOutput("t1_ready", 64'(req_ready), 64'h1);
      step();
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      checkOutput("t1_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t1_rsp_data", rsp_data, 64'd8);
      checkOutput("t1_rsp_id", 64'(rsp_id), 64'd0);
      checkOutput("t1_rsp_err", 64'(rsp_err), 64'd0);
      checkOutput("t1_op_count", 64'(op_count), 64'd1);

      // All requesters valid: strict rotation, one result per cycle.
      resetPulse();
      for (int i = 0; i < NREQ; i++) setOp(i, 64'hF << (16 * i), 3'b000);
      applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput("t2_grant", 64'(req_ready), 64'(1 << (k % 4)));
         if (k > 0) begin
            checkOutput("t2_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("t2_rsp_id", 64'(rsp_id), 64'((k - 1) % 4));
         end
         step();
      end

      // Consumer stalls with the buffer full.
      applyStimulus(4'b1111, 1'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("t3_stall_ready", 64'(req_ready), 64'd0);
         checkOutput("t3_hold_valid", 64'(rsp_valid), 64'd1);
         checkOutput("t3_hold_id", 64'(rsp_id), 64'd1);
         checkOutput("t3_hold_data", rsp_data, 64'd4);
         step();
      end
      applyStimulus(4'b1111, 1'b1);
      @(negedge clk);
      checkOutput("t3_drain_accept", 64'(req_ready), 64'h4);
      step();
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      checkOutput("t3_new_valid", 64'(rsp_valid), 64'd1);
      checkOutput("t3_new_id", 64'(rsp_id), 64'd2);
      checkOutput("t3_op_count", 64'(op_count), 64'd7);

      // Illegal function code.
      step();
      setOp(1, 64'hFFFF, 3'b111);
      applyStimulus(4'b0010, 1'b1);
      @(negedge clk);
      checkOutput("t4_ready", 64'(req_ready), 64'h2);
      step();
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
      checkOutput("t4_err", 64'(rsp_err), 64'd1);
      checkOutput("t4_data", rsp_data, 64'd0);
      checkOutput("t4_id", 64'(rsp_id), 64'd1);
      checkOutput("t4_op_count", 64'(op_count), 64'd8);

      // 32-bit versus 64-bit modes on a single bit at position 32.
      for (int k = 0; k < 4; k++) begin
         step();
         setOp(3, 64'h0000_0001_0000_0000, t5_func[k]);
         applyStimulus(4'b1000, 1'b1);
         @(negedge clk);
         checkOutput("t5_ready", 64'(req_ready), 64'h8);
         step();
         applyStimulus(4'b0000, 1'b1);
         @(negedge clk);
         checkOutput("t5_data", rsp_data, t5_exp[k]);
         checkOutput("t5_id", 64'(rsp_id), 64'd3);
         checkOutput("t5_op_count", 64'(op_count), 64'(9 + k));
      end

      // Asynchronous reset while the buffer is full.
      step();
      setOp(0, 64'h3, 3'b000);
      applyStimulus(4'b0001, 1'b0);
      step();
      applyStimulus(4'b0000, 1'b0);
      #2 reset = 1'b1;
      #1;
      checkOutput("t6_async_valid", 64'(rsp_valid), 64'd0);
      checkOutput("t6_async_count", 64'(op_count), 64'd0);
      checkOutput("t6_async_ready", 64'(req_ready), 64'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++) setOp(i, 64'h1 << i, 3'b000);
      applyStimulus(4'b1111, 1'b1);
      @(negedge clk);
      checkOutput("t6_first_pick", 64'(req_ready), 64'h1);
      step();
      applyStimulus(4'b0000, 1'b1);

      // Randomized traffic; requests hold until accepted.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = req_ready;
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || acc[i]) begin
               req_valid[i] = ($urandom_range(0, 99) < 60);
               setOp(i, rand_operand(), 3'($urandom_range(0, 7)));
            end
         end
         rsp_ready = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b1;
            step();
            reset = 1'b0;
         end
      end

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
